serial_word_deserializer_16_bit: RTL and testbench
==================================================

SERIAL_WORD_DESERIALIZER_16_BIT -- requirements
Module: serial_word_deserializer_16_bit

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 16, giving the number of data bits per word.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with ports Clk_In and Reset_N_In.
REQ-003 Port Clk_In SHALL be an input, 1 bit wide, and be the clock; all state updates on its rising edge.
REQ-004 Port Reset_N_In SHALL be an input, 1 bit wide, and be the synchronous, active-low reset.
REQ-005 Port Enable_In SHALL be an input, 1 bit wide; when low, strobes are ignored and all state holds.
REQ-006 Port Serial_Data_In SHALL be an input, 1 bit wide, carrying the serial bit from the upstream shift register's serial output.
REQ-007 Port Serial_Valid_In SHALL be an input, 1 bit wide, marking that Serial_Data_In is valid this cycle.
REQ-008 Port Msb_First_In SHALL be an input, 1 bit wide: 1 means bits arrive MSB first (upstream shift-left), 0 means LSB first (upstream shift-right).
REQ-009 Port Parallel_Data_Out SHALL be an output, WORD_WIDTH bits wide, carrying the assembled word.
REQ-010 Port Parallel_Valid_Out SHALL be an output, 1 bit wide, indicating the output holding register is full.
REQ-011 Port Parallel_Ready_In SHALL be an input, 1 bit wide, by which the consumer accepts the word.
REQ-012 Port Overrun_Out SHALL be an output, 1 bit wide, a sticky flag that a completed word was dropped.
REQ-013 Port Clear_Overrun_In SHALL be an input, 1 bit wide, that clears Overrun_Out.
REQ-014 Port Bit_Count_Out SHALL be an output, $clog2(WORD_WIDTH+1) bits wide, giving the bits collected in the current word.

Function
REQ-015 Each cycle with Enable_In=1 and Serial_Valid_In=1 SHALL accept exactly one bit into the collect register and increment the bit counter.
REQ-016 With Msb_First_In=1, the collect register SHALL shift as {collect[W-2:0], bit}; with Msb_First_In=0, it SHALL shift as {bit, collect[W-1:1]}.
REQ-017 Msb_First_In SHALL be sampled on the first bit of a word and held for that word; changes mid-word SHALL be ignored.
REQ-018 On the cycle the WORD_WIDTH-th bit is accepted, the complete word (including that bit) SHALL be transferred to the holding register on the same edge, and the counter SHALL wrap to 0.
REQ-019 Parallel_Valid_Out SHALL assert on the cycle after the final bit, giving 1-cycle latency from final bit to valid.
REQ-020 Parallel_Valid_Out SHALL stay high, and Parallel_Data_Out SHALL stay stable, until a cycle where Parallel_Valid_Out=1 and Parallel_Ready_In=1.
REQ-021 If a word completes in the same cycle the held word is consumed, the new word SHALL be loaded, Parallel_Valid_Out SHALL stay high, and no overrun SHALL be flagged.
REQ-022 If a word completes while the held word is pending and not consumed, the new word SHALL be dropped, the held word SHALL be kept, and Overrun_Out SHALL be set.
REQ-023 Clear_Overrun_In SHALL clear Overrun_Out next cycle; if a new overrun occurs in the same cycle, the set SHALL win.
REQ-024 Collection SHALL continue regardless of the holding register's state; the block SHALL never back-pressure the serial side.
REQ-025 The block SHALL have FSM states S_COLLECT and S_PARITY (the latter only if the parity feature is compiled in): S_COLLECT goes to S_PARITY after WORD_WIDTH bits when parity is compiled in; S_PARITY goes to S_COLLECT after one bit.
REQ-026 With Enable_In=0, Parallel_Ready_In SHALL still be honoured; it SHALL be the only input honoured.

Reset
REQ-027 With Reset_N_In=0 at a rising edge, the collect register, holding register and Parallel_Data_Out SHALL be 0; Parallel_Valid_Out=0; Overrun_Out=0; Bit_Count_Out=0; FSM=S_COLLECT; Parity_Error_Out=0.
REQ-028 Reset mid-word SHALL discard the partial word; the first strobed bit after reset release SHALL be bit 0 of a new word.

Configuration
REQ-029 When macro DESERIALIZER_PARITY_CHECK_EN is defined, each word SHALL be followed by one even-parity bit, and output Parity_Error_Out (1 bit) SHALL exist.
REQ-030 With DESERIALIZER_PARITY_CHECK_EN defined, Parity_Error_Out SHALL be loaded alongside the word, equal to (XOR of the data bits) XOR (parity bit), and be valid while Parallel_Valid_Out=1.
REQ-031 With DESERIALIZER_PARITY_CHECK_EN defined, a word's transfer SHALL happen on acceptance of the parity bit, not the last data bit.
REQ-032 Without DESERIALIZER_PARITY_CHECK_EN, there SHALL be no Parity_Error_Out port and no S_PARITY state, and words SHALL be exactly WORD_WIDTH bits.

Structure
REQ-033 Shared package usr_pkg SHALL hold the FSM state typedef, the default word width constant, and a bit-order enum (LSB_FIRST=0, MSB_FIRST=1) shared with the upstream shift register.
REQ-034 The block SHALL contain one sub-module, serial_bit_counter: a wrapping counter with enable, a terminal-count pulse, and synchronous active-low clear.

Verification
REQ-035 The bench SHALL cover: Msb_First_In=1, serial 16'hA5C3 sent MSB first with a strobe every cycle, Ready=1 -> Parallel_Data_Out=16'hA5C3, valid 1 cycle after bit 15.
REQ-036 The bench SHALL cover: Msb_First_In=0, 16'h8001 sent LSB first with gapped strobes -> output 16'h8001, Bit_Count_Out steps 0..15 then 0.
REQ-037 The bench SHALL cover: Ready=0, two words 16'h1111 then 16'h2222 -> output holds 16'h1111, Overrun_Out=1; then Clear_Overrun_In pulse -> Overrun_Out=0.
REQ-038 The bench SHALL cover: word 2 completes in the same cycle word 1 is consumed -> valid stays high, data becomes word 2, Overrun_Out=0.
REQ-039 The bench SHALL cover: Reset_N_In=0 after 7 bits, then a full 16'hFFFF -> output 16'hFFFF with no residue from the partial word.
REQ-040 The bench SHALL cover, with DESERIALIZER_PARITY_CHECK_EN defined: 16'h0001 with parity bit 0 -> Parity_Error_Out=1; with parity bit 1 -> Parity_Error_Out=0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the serial word path: word width default, bit order, deserializer FSM states.
// S_PARITY exists only when DESERIALIZER_PARITY_CHECK_EN is defined.
package usr_pkg;

   localparam int unsigned DEFAULT_WORD_WIDTH = 16;

   typedef enum logic {
      LSB_FIRST = 1'b0,
      MSB_FIRST = 1'b1
   } bit_order_t;

`ifdef DESERIALIZER_PARITY_CHECK_EN
   typedef enum logic {
      S_COLLECT = 1'b0,
      S_PARITY  = 1'b1
   } deser_state_t;
`else
   typedef enum logic {
      S_COLLECT = 1'b0
   } deser_state_t;
`endif

endpackage

// File: rtl/serial_bit_counter.sv
// Wrapping bit counter 0..MODULUS-1 with enable, terminal-count pulse and synchronous active-low clear.
module serial_bit_counter #(
   parameter int unsigned MODULUS     = 16,
   parameter int unsigned COUNT_WIDTH = $clog2(MODULUS + 1)
) (
   input  logic                   Clk_In,
   input  logic                   Clear_N_In,
   input  logic                   Enable_In,
   output logic [COUNT_WIDTH-1:0] Count_Out,
   output logic                   Terminal_Out
);

   localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(MODULUS - 1);

   // Pulses in the same cycle the final count is consumed, so the caller acts on that edge.
   assign Terminal_Out = Enable_In && (Count_Out == LAST);

   always_ff @(posedge Clk_In) begin
      if (!Clear_N_In) begin
         Count_Out <= '0;
      end else if (Terminal_Out) begin
         Count_Out <= '0;
      end else if (Enable_In) begin
         Count_Out <= Count_Out + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/serial_word_deserializer_16_bit.sv
// Collects serial bits into WORD_WIDTH-bit words with a one-deep output holding register and overrun flag.
// Define DESERIALIZER_PARITY_CHECK_EN to expect a trailing even-parity bit and expose Parity_Error_Out.
module serial_word_deserializer_16_bit
   import usr_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
   input  logic                            Clk_In,
   input  logic                            Reset_N_In,
   input  logic                            Enable_In,
   input  logic                            Serial_Data_In,
   input  logic                            Serial_Valid_In,
   input  logic                            Msb_First_In,
   output logic [WORD_WIDTH-1:0]           Parallel_Data_Out,
   output logic                            Parallel_Valid_Out,
   input  logic                            Parallel_Ready_In,
   output logic                            Overrun_Out,
   input  logic                            Clear_Overrun_In,
`ifdef DESERIALIZER_PARITY_CHECK_EN
   output logic                            Parity_Error_Out,
`endif
   output logic [$clog2(WORD_WIDTH+1)-1:0] Bit_Count_Out
);

   localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);

   logic [WORD_WIDTH-1:0] collect_q;
   logic [WORD_WIDTH-1:0] shifted;
   logic [WORD_WIDTH-1:0] word_done;
   bit_order_t            order_q;
   bit_order_t            word_order;
   logic                  accept;
   logic                  in_collect;
   logic                  first_bit;
   logic                  count_en;
   logic                  terminal;
   logic                  complete;
   logic                  consume;

`ifdef DESERIALIZER_PARITY_CHECK_EN
   deser_state_t state_q;
   logic         parity_err_done;

   assign in_collect      = (state_q == S_COLLECT);
   assign complete        = accept && (state_q == S_PARITY);
   assign word_done       = collect_q;
   assign parity_err_done = (^collect_q) ^ Serial_Data_In;
`else
   assign in_collect = 1'b1;
   assign complete   = terminal;
   assign word_done  = shifted;
`endif

   assign accept    = Enable_In && Serial_Valid_In;
   assign count_en  = accept && in_collect;
   assign first_bit = in_collect && (Bit_Count_Out == '0);
   assign consume   = Parallel_Valid_Out && Parallel_Ready_In;

   // Bit order is taken live on the first bit of a word and latched for the remainder.
   assign word_order = first_bit ? bit_order_t'(Msb_First_In) : order_q;
   assign shifted    = (word_order == MSB_FIRST) ? {collect_q[WORD_WIDTH-2:0], Serial_Data_In}
                                                 : {Serial_Data_In, collect_q[WORD_WIDTH-1:1]};

   serial_bit_counter #(
      .MODULUS     (WORD_WIDTH),
      .COUNT_WIDTH (CNT_W)
   ) u_bit_counter (
      .Clk_In       (Clk_In),
      .Clear_N_In   (Reset_N_In),
      .Enable_In    (count_en),
      .Count_Out    (Bit_Count_Out),
      .Terminal_Out (terminal)
   );

   always_ff @(posedge Clk_In) begin
      if (!Reset_N_In) begin
         collect_q <= '0;
         order_q   <= LSB_FIRST;
`ifdef DESERIALIZER_PARITY_CHECK_EN
         state_q   <= S_COLLECT;
`endif
      end else begin
         if (count_en) begin
            collect_q <= shifted;
            if (first_bit) begin
               order_q <= word_order;
            end
         end
`ifdef DESERIALIZER_PARITY_CHECK_EN
         case (state_q)
            S_COLLECT: if (terminal) state_q <= S_PARITY;
            S_PARITY:  if (accept)   state_q <= S_COLLECT;
            default:                 state_q <= S_COLLECT;
         endcase
`endif
      end
   end

   // A completing word loads if the slot is free or being drained this cycle; otherwise it is dropped.
   always_ff @(posedge Clk_In) begin
      if (!Reset_N_In) begin
         Parallel_Data_Out  <= '0;
         Parallel_Valid_Out <= 1'b0;
         Overrun_Out        <= 1'b0;
`ifdef DESERIALIZER_PARITY_CHECK_EN
         Parity_Error_Out   <= 1'b0;
`endif
      end else begin
         if (complete && (!Parallel_Valid_Out || Parallel_Ready_In)) begin
            Parallel_Data_Out  <= word_done;
            Parallel_Valid_Out <= 1'b1;
`ifdef DESERIALIZER_PARITY_CHECK_EN
            Parity_Error_Out   <= parity_err_done;
`endif
         end else if (consume) begin
            Parallel_Valid_Out <= 1'b0;
         end

         if (complete && Parallel_Valid_Out && !Parallel_Ready_In) begin
            Overrun_Out <= 1'b1;
         end else if (Enable_In && Clear_Overrun_In) begin
            Overrun_Out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_deserializer_16_bit.sv
// Self-checking bench for serial_word_deserializer_16_bit; covers the parity variant when
// DESERIALIZER_PARITY_CHECK_EN is defined.
module tb_serial_word_deserializer_16_bit;

   localparam int W = 16;
`ifdef DESERIALIZER_PARITY_CHECK_EN
   localparam int TOT = W + 1;
`else
   localparam int TOT = W;
`endif
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          sdata = 1'b0;
   logic          svalid = 1'b0;
   logic          msb = 1'b0;
   logic          ready = 1'b0;
   logic          clr = 1'b0;
   logic [W-1:0]  pdata;
   logic          pvalid;
   logic          ovr;
   logic [CW-1:0] cnt;
`ifdef DESERIALIZER_PARITY_CHECK_EN
   logic          perr;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of received bits and the holding slot
   logic         mq[$];
   logic         m_order = 1'b0;
   logic [W-1:0] m_data  = '0;
   logic         m_valid = 1'b0;
   logic         m_ovr   = 1'b0;
   logic         m_perr  = 1'b0;

   always #5 clk = ~clk;

   serial_word_deserializer_16_bit #(.WORD_WIDTH(W)) dut (
      .Clk_In             (clk),
      .Reset_N_In         (rst_n),
      .Enable_In          (en),
      .Serial_Data_In     (sdata),
      .Serial_Valid_In    (svalid),
      .Msb_First_In       (msb),
      .Parallel_Data_Out  (pdata),
      .Parallel_Valid_Out (pvalid),
      .Parallel_Ready_In  (ready),
      .Overrun_Out        (ovr),
      .Clear_Overrun_In   (clr),
`ifdef DESERIALIZER_PARITY_CHECK_EN
      .Parity_Error_Out   (perr),
`endif
      .Bit_Count_Out      (cnt)
   );

   function automatic logic [CW-1:0] m_count();
      if (mq.size() >= W) return '0;
      return CW'(mq.size());
   endfunction

   // Bit k of a transmission: data bits in the chosen order, then the even-parity bit.
   function automatic logic tx_bit(input logic [W-1:0] w, input logic m, input int k);
      if (k >= W) return ^w;
      return m ? w[W-1-k] : w[k];
   endfunction

   task automatic model_edge();
      logic [W-1:0] w;
      logic         pe;
      logic         done;
      logic         setov;
      w = '0; pe = 1'b0; done = 1'b0;
      if (!rst_n) begin
         mq.delete();
         m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_order = 1'b0;
         return;
      end
      if (en && svalid) begin
         if (mq.size() == 0) m_order = msb;
         mq.push_back(sdata);
         if (mq.size() == TOT) begin
            for (int i = 0; i < W; i++) begin
               if (m_order) w[W-1-i] = mq[i];
               else         w[i]     = mq[i];
            end
            pe = ^w;
            if (TOT > W) pe = pe ^ mq[W];
            mq.delete();
            done = 1'b1;
         end
      end
      setov = done && m_valid && !ready;
      if (done && (!m_valid || ready)) begin
         m_data = w; m_valid = 1'b1; m_perr = pe;
      end else if (m_valid && ready) begin
         m_valid = 1'b0;
      end
      if (setov) m_ovr = 1'b1;
      else if (en && clr) m_ovr = 1'b0;
   endtask

   task automatic step(input logic v, input logic b, input logic m, input logic rdy,
                       input logic c, input logic e, input logic rn);
      svalid = v; sdata = b; msb = m; ready = rdy; clr = c; en = e; rst_n = rn;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input logic m, input logic rdy,
                            input int from, input int to);
      for (int k = from; k < to; k++) step(1'b1, tx_bit(w, m, k), m, rdy, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (pdata !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", pdata); end
      n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pvalid); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
      n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt); end
`ifdef DESERIALIZER_PARITY_CHECK_EN
      n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b expected 0", perr); end
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_msb_first();
      send_bits(16'hA5C3, 1'b1, 1'b1, 0, TOT - 1);
      n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL msb_early_valid: got %b expected 0", pvalid); end
      send_bits(16'hA5C3, 1'b1, 1'b1, TOT - 1, TOT);
      n_checks++; if (pvalid !== 1'b1) begin n_fail++; $display("FAIL msb_valid: got %b expected 1", pvalid); end
      n_checks++; if (pdata !== 16'hA5C3 || pdata !== m_data) begin n_fail++; $display("FAIL msb_data: got %h expected a5c3", pdata); end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL msb_consume: got %b expected 0", pvalid); end
   endtask

   task automatic test_lsb_gapped();
      logic [CW-1:0] ec;
      for (int k = 0; k < TOT; k++) begin
         ec = (k < W) ? CW'(k) : '0;
         n_checks++; if (cnt !== ec) begin n_fail++; $display("FAIL lsb_count_%0d: got %0d expected %0d", k, cnt, ec); end
         // msb toggles after the first bit must be ignored
         step(1'b1, tx_bit(16'h8001, 1'b0, k), (k == 0) ? 1'b0 : 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
         step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
      end
      n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL lsb_count_wrap: got %0d expected 0", cnt); end
      n_checks++; if (pvalid !== 1'b1) begin n_fail++; $display("FAIL lsb_valid: got %b expected 1", pvalid); end
      n_checks++; if (pdata !== 16'h8001) begin n_fail++; $display("FAIL lsb_data: got %h expected 8001", pdata); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_overrun();
      send_bits(16'h1111, 1'b1, 1'b0, 0, TOT);
      n_checks++; if (pdata !== 16'h1111 || ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %h/%b expected 1111/0", pdata, ovr); end
      send_bits(16'h2222, 1'b1, 1'b0, 0, TOT);
      n_checks++; if (pdata !== 16'h1111 || pvalid !== 1'b1) begin n_fail++; $display("FAIL ovr_hold: got %h/%b expected 1111/1", pdata, pvalid); end
      n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ovr); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
      send_bits(16'h3333, 1'b1, 1'b0, 0, TOT - 1);
      step(1'b1, tx_bit(16'h3333, 1'b1, TOT - 1), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      n_checks++; if (ovr !== 1'b1 || pdata !== 16'h1111) begin n_fail++; $display("FAIL ovr_set_wins: got %b/%h expected 1/1111", ovr, pdata); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_clear_disabled: got %b expected 1", ovr); end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++; if (ovr !== 1'b0 || pvalid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b/%b expected 0/0", ovr, pvalid); end
   endtask

   task automatic test_back_to_back();
      send_bits(16'h1234, 1'b1, 1'b0, 0, TOT);
      send_bits(16'hBEEF, 1'b1, 1'b0, 0, TOT - 1);
      send_bits(16'hBEEF, 1'b1, 1'b1, TOT - 1, TOT);
      n_checks++; if (pvalid !== 1'b1 || pdata !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_data: got %b/%h expected 1/beef", pvalid, pdata); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", ovr); end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_enable_low();
      send_bits(16'h00FF, 1'b0, 1'b0, 0, TOT);
      send_bits(16'h5A3C, 1'b1, 1'b0, 0, 3);
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (cnt !== CW'(3) || pvalid !== 1'b1) begin n_fail++; $display("FAIL en_hold: got %0d/%b expected 3/1", cnt, pvalid); end
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++; if (pvalid !== 1'b0 || cnt !== CW'(3)) begin n_fail++; $display("FAIL en_ready: got %b/%0d expected 0/3", pvalid, cnt); end
      send_bits(16'h5A3C, 1'b1, 1'b0, 3, TOT);
      n_checks++; if (pdata !== 16'h5A3C || pvalid !== 1'b1) begin n_fail++; $display("FAIL en_resume: got %h/%b expected 5a3c/1", pdata, pvalid); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_midword();
      send_bits(16'h1234, 1'b1, 1'b1, 0, 7);
      n_checks++; if (cnt !== CW'(7)) begin n_fail++; $display("FAIL rmw_count: got %0d expected 7", cnt); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL rmw_count_reset: got %0d expected 0", cnt); end
      send_bits(16'hFFFF, 1'b0, 1'b1, 0, TOT - 1);
      n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL rmw_early_valid: got %b expected 0", pvalid); end
      send_bits(16'hFFFF, 1'b0, 1'b1, TOT - 1, TOT);
      n_checks++; if (pvalid !== 1'b1 || pdata !== 16'hFFFF) begin n_fail++; $display("FAIL rmw_data: got %b/%h expected 1/ffff", pvalid, pdata); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask

`ifdef DESERIALIZER_PARITY_CHECK_EN
   task automatic test_parity();
      send_bits(16'h0001, 1'b1, 1'b0, 0, W);
      n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL par_wait: got %b expected 0", pvalid); end
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      n_checks++; if (pvalid !== 1'b1 || pdata !== 16'h0001 || perr !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b/%h/%b expected 1/0001/1", pvalid, pdata, perr); end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      send_bits(16'h0001, 1'b1, 1'b0, 0, W);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      n_checks++; if (pvalid !== 1'b1 || perr !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b/%b expected 1/0", pvalid, perr); end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 63) != 0));
         n_checks++;
         if (pvalid !== m_valid || ovr !== m_ovr || cnt !== m_count() ||
             (m_valid && pdata !== m_data)) begin
            n_fail++;
            $display("FAIL rand_%0d: got v=%b o=%b c=%0d d=%h expected v=%b o=%b c=%0d d=%h",
                     i, pvalid, ovr, cnt, pdata, m_valid, m_ovr, m_count(), m_data);
         end
`ifdef DESERIALIZER_PARITY_CHECK_EN
         n_checks++;
         if (m_valid && perr !== m_perr) begin
            n_fail++; $display("FAIL rand_parity_%0d: got %b expected %b", i, perr, m_perr);
         end
`endif
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_msb_first();
      test_lsb_gapped();
      test_overrun();
      test_back_to_back();
      test_enable_low();
      test_reset_midword();
`ifdef DESERIALIZER_PARITY_CHECK_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
